// File: rtl/crc_serial_engine.sv
// rtl/crc_serial_engine.sv - bit-serial CRC engine (CRC7 / CRC16-CCITT) with result compare
//
// Computes a CRC over LEN message bits (MSB first) in LFSR form and compares
// the final value against EXPECTED, which is latched on START.
//
// Optional feature macro: CRC_APPEND_EN. When it is defined, the final CRC is
// shifted out on DOUT/DOUT_VALID (MSB first, CRC_W cycles) before DONE.
//
// Ports:
//   CLK        in   system clock, posedge
//   RST_N      in   asynchronous active-low reset
//   START      in   single-cycle pulse: load INIT/LEN/EXPECTED, begin a run
//   LEN        in   message length in bits, sampled on START
//   DIN        in   message bit
//   DIN_VALID  in   DIN is valid this cycle
//   DIN_READY  out  engine accepts a bit this cycle (RUN only)
//   EXPECTED   in   reference CRC, sampled on START
//   CRC        out  current CRC register
//   CRC_VALID  out  CRC is final; held until the next START
//   MATCH      out  CRC == EXPECTED, meaningful while CRC_VALID
//   ERR        out  CRC_VALID & ~MATCH, sticky until the next START
//   BUSY       out  high outside IDLE and DONE
//   DOUT       out  serialised CRC bit (CRC_APPEND_EN only)
//   DOUT_VALID out  DOUT is valid (CRC_APPEND_EN only)

module crc_serial_engine #(
  parameter int                CRC_W = 7,
  parameter logic [CRC_W-1:0]  POLY  = 'h09,
  parameter logic [CRC_W-1:0]  INIT  = '0,
  parameter int                LEN_W = 13
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [LEN_W-1:0]  LEN,
  input  logic              DIN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  input  logic [CRC_W-1:0]  EXPECTED,
  output logic [CRC_W-1:0]  CRC,
`ifdef CRC_APPEND_EN
  output logic              DOUT,
  output logic              DOUT_VALID,
`endif
  output logic              CRC_VALID,
  output logic              MATCH,
  output logic              ERR,
  output logic              BUSY
);

`ifdef CRC_APPEND_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_DONE   = 2'd2,
    S_APPEND = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
`endif

  state_t             state_q;
  state_t             state_d;
  logic [CRC_W-1:0]   crc_q;
  logic [CRC_W-1:0]   exp_q;
  logic [LEN_W-1:0]   count_q;
  logic               crc_valid_q;
  logic               match_q;
  logic               err_q;

  logic               accept;
  logic               last_bit;
  logic               fb;
  logic [CRC_W-1:0]   crc_step;

`ifdef CRC_APPEND_EN
  // Separate shifter so CRC keeps showing the final value during APPEND.
  logic [CRC_W-1:0]   shift_q;
  logic               append_last;
`endif

  // START takes priority over a bit offered in the same cycle.
  assign accept   = (state_q == S_RUN) && DIN_VALID && !START;
  assign last_bit = accept && (count_q == LEN_W'(1));

  assign fb       = crc_q[CRC_W-1] ^ DIN;
  assign crc_step = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);

`ifdef CRC_APPEND_EN
  // count_q is reused as the DOUT bit counter while in APPEND.
  assign append_last = (state_q == S_APPEND) && (count_q == LEN_W'(1));
`endif

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_d    = state_q;
    DIN_READY  = 1'b0;
    BUSY       = 1'b0;
`ifdef CRC_APPEND_EN
    DOUT       = 1'b0;
    DOUT_VALID = 1'b0;
`endif
    if (START) begin
      state_d = (LEN == '0) ? S_DONE : S_RUN;
    end else begin
      case (state_q)
        S_RUN: begin
          if (last_bit) begin
`ifdef CRC_APPEND_EN
            state_d = S_APPEND;
`else
            state_d = S_DONE;
`endif
          end
        end
`ifdef CRC_APPEND_EN
        S_APPEND: begin
          if (append_last) state_d = S_DONE;
        end
`endif
        default: state_d = state_q;
      endcase
    end

    case (state_q)
      S_RUN: begin
        DIN_READY = 1'b1;
        BUSY      = 1'b1;
      end
`ifdef CRC_APPEND_EN
      S_APPEND: begin
        BUSY       = 1'b1;
        DOUT       = shift_q[CRC_W-1];
        DOUT_VALID = 1'b1;
      end
`endif
      default: begin
        DIN_READY = 1'b0;
        BUSY      = 1'b0;
      end
    endcase
  end

  // Datapath: CRC register, bit counter, latched reference and result flags
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      crc_q       <= INIT;
      exp_q       <= '0;
      count_q     <= '0;
      crc_valid_q <= 1'b0;
      match_q     <= 1'b0;
      err_q       <= 1'b0;
`ifdef CRC_APPEND_EN
      shift_q     <= '0;
`endif
    end else if (START) begin
      crc_q       <= INIT;
      exp_q       <= EXPECTED;
      count_q     <= LEN;
      // An empty message is final immediately: the result is INIT.
      crc_valid_q <= (LEN == '0);
      match_q     <= (LEN == '0) && (INIT == EXPECTED);
      err_q       <= (LEN == '0) && (INIT != EXPECTED);
    end else if (accept) begin
      crc_q   <= crc_step;
      count_q <= count_q - LEN_W'(1);
      if (last_bit) begin
`ifdef CRC_APPEND_EN
        shift_q <= crc_step;
        count_q <= LEN_W'(CRC_W);
`else
        crc_valid_q <= 1'b1;
        match_q     <= (crc_step == exp_q);
        err_q       <= (crc_step != exp_q);
`endif
      end
    end
`ifdef CRC_APPEND_EN
    else if (state_q == S_APPEND) begin
      shift_q <= {shift_q[CRC_W-2:0], 1'b0};
      count_q <= count_q - LEN_W'(1);
      if (append_last) begin
        crc_valid_q <= 1'b1;
        match_q     <= (crc_q == exp_q);
        err_q       <= (crc_q != exp_q);
      end
    end
`endif
  end

  assign CRC       = crc_q;
  assign CRC_VALID = crc_valid_q;
  assign MATCH     = match_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_crc_serial_engine.sv
// tb/tb_crc_serial_engine.sv - self-checking bench for crc_serial_engine (CRC7 and CRC16 instances)

module tb_crc_serial_engine;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst_n;

  // CRC7 instance
  logic        start;
  logic [12:0] len;
  logic        din;
  logic        din_valid;
  logic [6:0]  expected;
  logic        din_ready;
  logic [6:0]  crc;
  logic        crc_valid;
  logic        match;
  logic        err;
  logic        busy;
`ifdef CRC_APPEND_EN
  logic        dout;
  logic        dout_valid;
`endif

  // CRC16 instance
  logic        s_start;
  logic [12:0] s_len;
  logic        s_din;
  logic        s_din_valid;
  logic [15:0] s_expected;
  logic        s_din_ready;
  logic [15:0] s_crc;
  logic        s_crc_valid;
  logic        s_match;
  logic        s_err;
  logic        s_busy;
`ifdef CRC_APPEND_EN
  logic        s_dout;
  logic        s_dout_valid;
`endif

  crc_serial_engine dut7 (
    .CLK       (CLK),
    .RST_N     (rst_n),
    .START     (start),
    .LEN       (len),
    .DIN       (din),
    .DIN_VALID (din_valid),
    .DIN_READY (din_ready),
    .EXPECTED  (expected),
    .CRC       (crc),
`ifdef CRC_APPEND_EN
    .DOUT      (dout),
    .DOUT_VALID(dout_valid),
`endif
    .CRC_VALID (crc_valid),
    .MATCH     (match),
    .ERR       (err),
    .BUSY      (busy)
  );

  crc_serial_engine #(
    .CRC_W(16),
    .POLY (16'h1021),
    .INIT (16'h0000),
    .LEN_W(13)
  ) dut16 (
    .CLK       (CLK),
    .RST_N     (rst_n),
    .START     (s_start),
    .LEN       (s_len),
    .DIN       (s_din),
    .DIN_VALID (s_din_valid),
    .DIN_READY (s_din_ready),
    .EXPECTED  (s_expected),
    .CRC       (s_crc),
`ifdef CRC_APPEND_EN
    .DOUT      (s_dout),
    .DOUT_VALID(s_dout_valid),
`endif
    .CRC_VALID (s_crc_valid),
    .MATCH     (s_match),
    .ERR       (s_err),
    .BUSY      (s_busy)
  );

  int checks = 0;
  int errors = 0;
  bit msg [0:4095];

  // Reference: polynomial long division of message * x^w by the full generator.
  function automatic int ref_crc(int w, int poly, int n);
    int rem;
    int b;
    rem = 0;
    for (int i = 0; i < n + w; i++) begin
      b = (i < n) ? int'(msg[i]) : 0;
      rem = (rem << 1) | b;
      if (((rem >> w) & 1) == 1) rem = rem ^ ((1 << w) | poly);
    end
    return rem;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_word(longint v, int n);
    for (int i = 0; i < n; i++) msg[i] = v[n-1-i];
  endtask

  task automatic start7(int l, int e);
    start    = 1'b1;
    len      = 13'(l);
    expected = 7'(e);
    step();
    start    = 1'b0;
  endtask

  task automatic feed7(int from, int to, bit stall);
    for (int i = from; i < to; i++) begin
      if (stall) begin
        din_valid = 1'b0;
        din       = 1'($urandom);
        step();
      end
      din       = msg[i];
      din_valid = 1'b1;
      step();
    end
    din_valid = 1'b0;
  endtask

  // Cycles between the last accepted bit and the result becoming visible.
  task automatic finish7();
`ifdef CRC_APPEND_EN
    repeat (7) step();
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 0; len = 0; din = 0; din_valid = 0; expected = 0;
    s_start = 0; s_len = 0; s_din = 0; s_din_valid = 0; s_expected = 0;
    #12;
    checks++;
    if ({crc, din_ready, crc_valid, match, err, busy} !== {7'h00, 5'b00000}) begin
      errors++;
      $display("FAIL reset_outputs got crc=%h rdy=%b v=%b m=%b e=%b b=%b want all zero",
               crc, din_ready, crc_valid, match, err, busy);
    end
    checks++;
    if ({s_crc, s_busy, s_crc_valid} !== 18'h0) begin
      errors++;
      $display("FAIL reset_crc16 got crc=%h b=%b v=%b want 0", s_crc, s_busy, s_crc_valid);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_cmd0();
    int r;
    load_word(64'h4000000000, 40);
    r = ref_crc(7, 'h09, 40);
    start7(40, 'h4A);
    checks++;
    if (busy !== 1'b1 || din_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd0_run got busy=%b rdy=%b want 1 1", busy, din_ready);
    end
    feed7(0, 39, 1'b0);
    checks++;
    if (crc_valid !== 1'b0) begin
      errors++;
      $display("FAIL cmd0_early_valid got %b want 0", crc_valid);
    end
    feed7(39, 40, 1'b0);
    finish7();
    checks++;
    if (crc_valid !== 1'b1) begin
      errors++;
      $display("FAIL cmd0_valid got %b want 1", crc_valid);
    end
    checks++;
    if (crc !== 7'h4A || crc !== 7'(r)) begin
      errors++;
      $display("FAIL cmd0_crc got %h want 4a (model %h)", crc, 7'(r));
    end
    checks++;
    if (match !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b0) begin
      errors++;
      $display("FAIL cmd0_flags got m=%b e=%b b=%b rdy=%b want 1 0 0 0", match, err, busy, din_ready);
    end
  endtask

  task automatic test_cmd8_stall();
    int cyc;
    int want_cyc;
    bit ready_ok;
    load_word(64'h48000001AA, 40);
    start7(40, 'h43);
    cyc = 0;
    ready_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      din_valid = 1'b0;
      din       = 1'($urandom);
      if (din_ready !== 1'b1) ready_ok = 1'b0;
      step(); cyc++;
      if (din_ready !== 1'b1) ready_ok = 1'b0;
      din       = msg[i];
      din_valid = 1'b1;
      step(); cyc++;
    end
    din_valid = 1'b0;
`ifdef CRC_APPEND_EN
    repeat (7) begin step(); cyc++; end
    want_cyc = 87;
`else
    want_cyc = 80;
`endif
    checks++;
    if (!ready_ok) begin
      errors++;
      $display("FAIL cmd8_ready_stall got low during stall want 1");
    end
    checks++;
    if (cyc != want_cyc || crc_valid !== 1'b1) begin
      errors++;
      $display("FAIL cmd8_latency got cyc=%0d valid=%b want %0d 1", cyc, crc_valid, want_cyc);
    end
    checks++;
    if (crc !== 7'h43 || match !== 1'b1) begin
      errors++;
      $display("FAIL cmd8_crc got %h m=%b want 43 1", crc, match);
    end
  endtask

  task automatic test_crc16();
    s_start = 1'b1; s_len = 13'd4096; s_expected = 16'h7FA1;
    step();
    s_start = 1'b0;
    s_din = 1'b1; s_din_valid = 1'b1;
    repeat (4096) step();
    s_din_valid = 1'b0;
`ifdef CRC_APPEND_EN
    repeat (16) step();
`endif
    checks++;
    if (s_crc !== 16'h7FA1 || s_crc_valid !== 1'b1) begin
      errors++;
      $display("FAIL crc16_ones got %h v=%b want 7fa1 1", s_crc, s_crc_valid);
    end
    checks++;
    if (s_match !== 1'b1 || s_err !== 1'b0) begin
      errors++;
      $display("FAIL crc16_match got m=%b e=%b want 1 0", s_match, s_err);
    end
  endtask

  task automatic test_err_sticky();
    load_word(64'h4000000000, 40);
    start7(40, 'h4B);
    feed7(0, 40, 1'b0);
    finish7();
    checks++;
    if (err !== 1'b1 || match !== 1'b0 || crc_valid !== 1'b1) begin
      errors++;
      $display("FAIL err_set got e=%b m=%b v=%b want 1 0 1", err, match, crc_valid);
    end
    // DIN_VALID in DONE must be ignored.
    for (int i = 0; i < 6; i++) begin
      din_valid = 1'(i);
      din       = 1'($urandom);
      step();
    end
    din_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || crc !== 7'h4A || crc_valid !== 1'b1) begin
      errors++;
      $display("FAIL err_hold got e=%b crc=%h v=%b want 1 4a 1", err, crc, crc_valid);
    end
    start7(40, 'h4A);
    checks++;
    if (err !== 1'b0 || crc_valid !== 1'b0 || crc !== 7'h00) begin
      errors++;
      $display("FAIL err_clear got e=%b v=%b crc=%h want 0 0 00", err, crc_valid, crc);
    end
    feed7(0, 40, 1'b0);
    finish7();
  endtask

  task automatic test_abort();
    start7(40, 'h11);
    for (int i = 0; i < 20; i++) begin
      din = 1'($urandom); din_valid = 1'b1;
      step();
    end
    // Restart with a bit offered in the same cycle: the bit must be dropped.
    start = 1'b1; len = 13'd40; expected = 7'h4A; din = 1'b1; din_valid = 1'b1;
    step();
    start = 1'b0; din_valid = 1'b0;
    checks++;
    if (crc !== 7'h00 || crc_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_restart got crc=%h v=%b b=%b want 00 0 1", crc, crc_valid, busy);
    end
    load_word(64'h4000000000, 40);
    feed7(0, 40, 1'b0);
    finish7();
    checks++;
    if (crc !== 7'h4A || match !== 1'b1 || crc_valid !== 1'b1) begin
      errors++;
      $display("FAIL abort_result got crc=%h m=%b v=%b want 4a 1 1", crc, match, crc_valid);
    end
  endtask

  task automatic test_async_reset();
    load_word(64'h48000001AA, 40);
    start7(40, 'h43);
    feed7(0, 10, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({crc, din_ready, crc_valid, match, err, busy} !== {7'h00, 5'b00000}) begin
      errors++;
      $display("FAIL async_reset got crc=%h rdy=%b v=%b m=%b e=%b b=%b want all zero",
               crc, din_ready, crc_valid, match, err, busy);
    end
    #2;
    rst_n = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || crc_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_idle got b=%b v=%b want 0 0", busy, crc_valid);
    end
  endtask

  task automatic test_len0();
    start7(0, 0);
    checks++;
    if (crc_valid !== 1'b1 || crc !== 7'h00 || match !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL len0_match got v=%b crc=%h m=%b e=%b b=%b want 1 00 1 0 0",
               crc_valid, crc, match, err, busy);
    end
    start7(0, 5);
    checks++;
    if (crc_valid !== 1'b1 || match !== 1'b0 || err !== 1'b1) begin
      errors++;
      $display("FAIL len0_mismatch got v=%b m=%b e=%b want 1 0 1", crc_valid, match, err);
    end
  endtask

  task automatic test_len1();
    int r;
    msg[0] = 1'b1;
    r = ref_crc(7, 'h09, 1);
    start7(1, r);
    feed7(0, 1, 1'b0);
    finish7();
    checks++;
    if (crc !== 7'(r) || match !== 1'b1 || crc_valid !== 1'b1) begin
      errors++;
      $display("FAIL len1 got crc=%h m=%b v=%b want %h 1 1", crc, match, crc_valid, 7'(r));
    end
  endtask

  task automatic test_random();
    int n;
    int r;
    int e;
    bit want;
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 64);
      for (int i = 0; i < n; i++) msg[i] = 1'($urandom);
      r = ref_crc(7, 'h09, n);
      want = 1'($urandom);
      e = want ? r : (r ^ $urandom_range(1, 127));
      start7(n, e);
      feed7(0, n, 1'($urandom));
      finish7();
      checks++;
      if (crc !== 7'(r) || match !== want || err !== !want || crc_valid !== 1'b1) begin
        errors++;
        $display("FAIL random_%0d got crc=%h m=%b e=%b v=%b want %h %b %b 1",
                 t, crc, match, err, crc_valid, 7'(r), want, !want);
      end
    end
  endtask

`ifdef CRC_APPEND_EN
  task automatic test_append();
    int r;
    load_word(64'h4000000000, 40);
    r = ref_crc(7, 'h09, 40);
    start7(40, 'h4A);
    feed7(0, 40, 1'b0);
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (dout_valid !== 1'b1 || dout !== r[6-k] || crc_valid !== 1'b0 || crc !== 7'(r)) begin
        errors++;
        $display("FAIL append_bit%0d got dv=%b d=%b v=%b crc=%h want 1 %b 0 %h",
                 k, dout_valid, dout, crc_valid, crc, r[6-k], 7'(r));
      end
      step();
    end
    checks++;
    if (crc_valid !== 1'b1 || match !== 1'b1 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL append_done got v=%b m=%b dv=%b want 1 1 0", crc_valid, match, dout_valid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cmd0();
    test_cmd8_stall();
    test_crc16();
    test_err_sticky();
    test_abort();
    test_async_reset();
    test_len0();
    test_len1();
    test_random();
`ifdef CRC_APPEND_EN
    test_append();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
